tap_ctrl: RTL and testbench

IEEE 1149.1 TAP controller that sequences the JTAG data registers. It contains the 16-state TAP FSM, a 4-bit instruction register and a 1-bit bypass register. It drives the capture/shift/update/reset strobes and register selects consumed by the ID register. It also owns the TDO output mux and the TDO enable.

---
 rtl/tap_pkg.sv | 29 ++
 rtl/tap_fsm.sv | 45 ++++
 rtl/tap_ctrl.sv | 112 +++++++++++
 tb/tb_tap_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/tap_pkg.sv
// Shared TAP definitions: state encodings and instruction constants.
package tap_pkg;

    typedef enum logic [3:0] {
        ST_TLR      = 4'hF,
        ST_RTI      = 4'hC,
        ST_SEL_DR   = 4'h7,
        ST_CAP_DR   = 4'h6,
        ST_SH_DR    = 4'h2,
        ST_EX1_DR   = 4'h1,
        ST_PAUSE_DR = 4'h3,
        ST_EX2_DR   = 4'h0,
        ST_UPD_DR   = 4'h5,
        ST_SEL_IR   = 4'h4,
        ST_CAP_IR   = 4'hE,
        ST_SH_IR    = 4'hA,
        ST_EX1_IR   = 4'h9,
        ST_PAUSE_IR = 4'hB,
        ST_EX2_IR   = 4'h8,
        ST_UPD_IR   = 4'hD
    } tap_state_t;

    localparam int unsigned IR_WIDTH_DEF  = 4;
    localparam logic [3:0]  IDCODE_OP_DEF = 4'b0001;
    localparam logic [3:0]  BYPASS_OP_DEF = 4'b1111;
    // Value parallel-loaded into the IR shifter in Capture-IR (LSBs = 01).
    localparam logic [3:0]  IR_CAPTURE    = 4'b0001;

endpackage

// File: rtl/tap_fsm.sv
// 16-state IEEE 1149.1 TAP state machine, advanced by TMS on rising TCK.
module tap_fsm
    import tap_pkg::*;
(
    input  logic       TCK,
    input  logic       TRST,
    input  logic       TMS,
    output tap_state_t tap_state
);

    tap_state_t state_q, state_d;

    // State register; TRST forces Test-Logic-Reset asynchronously.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) state_q <= ST_TLR;
        else       state_q <= state_d;
    end

    // Next-state decode from current state and TMS.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_TLR:      state_d = TMS ? ST_TLR      : ST_RTI;
            ST_RTI:      state_d = TMS ? ST_SEL_DR   : ST_RTI;
            ST_SEL_DR:   state_d = TMS ? ST_SEL_IR   : ST_CAP_DR;
            ST_CAP_DR:   state_d = TMS ? ST_EX1_DR   : ST_SH_DR;
            ST_SH_DR:    state_d = TMS ? ST_EX1_DR   : ST_SH_DR;
            ST_EX1_DR:   state_d = TMS ? ST_UPD_DR   : ST_PAUSE_DR;
            ST_PAUSE_DR: state_d = TMS ? ST_EX2_DR   : ST_PAUSE_DR;
            ST_EX2_DR:   state_d = TMS ? ST_UPD_DR   : ST_SH_DR;
            ST_UPD_DR:   state_d = TMS ? ST_SEL_DR   : ST_RTI;
            ST_SEL_IR:   state_d = TMS ? ST_TLR      : ST_CAP_IR;
            ST_CAP_IR:   state_d = TMS ? ST_EX1_IR   : ST_SH_IR;
            ST_SH_IR:    state_d = TMS ? ST_EX1_IR   : ST_SH_IR;
            ST_EX1_IR:   state_d = TMS ? ST_UPD_IR   : ST_PAUSE_IR;
            ST_PAUSE_IR: state_d = TMS ? ST_EX2_IR   : ST_PAUSE_IR;
            ST_EX2_IR:   state_d = TMS ? ST_UPD_IR   : ST_SH_IR;
            ST_UPD_IR:   state_d = TMS ? ST_SEL_DR   : ST_RTI;
            default:     state_d = ST_TLR;
        endcase
    end

    assign tap_state = state_q;

endmodule

// File: rtl/tap_ctrl.sv
// JTAG TAP controller: FSM, instruction register, bypass bit, strobes and TDO.
module tap_ctrl
    import tap_pkg::*;
#(
    parameter int unsigned             IR_WIDTH  = IR_WIDTH_DEF,
    parameter logic [IR_WIDTH-1:0]     IDCODE_OP = IR_WIDTH'(IDCODE_OP_DEF),
    parameter logic [IR_WIDTH-1:0]     BYPASS_OP = IR_WIDTH'(BYPASS_OP_DEF)
)(
    input  logic                TCK,
    input  logic                TRST,
    input  logic                TMS,
    input  logic                TDI,
    output logic                TDO,
    output logic                TDO_EN,
    input  logic                idr_tdo,
    output logic                tlr_reset,
    output logic                dr_capture,
    output logic                dr_shift,
    output logic                dr_update,
    output logic                idr_select,
    output logic                bypass_select,
    output logic [IR_WIDTH-1:0] ir_value,
    output logic [3:0]          tap_state
);

    localparam logic [IR_WIDTH-1:0] IR_CAP = IR_WIDTH'(IR_CAPTURE);

    tap_state_t          state;
    logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic                bypass_q, bypass_d;
    logic                tdo_q, tdo_d;
    logic                tdo_en_q, tdo_en_d;

    tap_fsm u_fsm (
        .TCK       (TCK),
        .TRST      (TRST),
        .TMS       (TMS),
        .tap_state (state)
    );

    // Moore decode of strobes and register selects.
    always_comb begin
        tlr_reset     = (state == ST_TLR);
        dr_capture    = (state == ST_CAP_DR);
        dr_shift      = (state == ST_SH_DR);
        dr_update     = (state == ST_UPD_DR);
        // TLR overrides the held instruction so the reset opcode is visible
        // for the whole time the controller sits in TLR.
        ir_value      = tlr_reset ? IDCODE_OP : ir_q;
        idr_select    = (ir_value == IDCODE_OP);
        bypass_select = (ir_value == BYPASS_OP) || !idr_select;
        tap_state     = state;
    end

    // Next values of IR shifter, instruction latch and bypass bit.
    always_comb begin
        ir_sr_d  = ir_sr_q;
        ir_d     = ir_q;
        bypass_d = bypass_q;
        case (state)
            ST_CAP_IR: ir_sr_d = IR_CAP;
            ST_SH_IR:  ir_sr_d = {TDI, ir_sr_q[IR_WIDTH-1:1]};
            ST_UPD_IR: ir_d    = ir_sr_q;
            ST_TLR:    ir_d    = IDCODE_OP;
            ST_CAP_DR: if (bypass_select) bypass_d = 1'b0;
            ST_SH_DR:  if (bypass_select) bypass_d = TDI;
            default: ;
        endcase
    end

    // Rising-edge registers for IR path and bypass bit.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            ir_sr_q  <= '0;
            ir_q     <= IDCODE_OP;
            bypass_q <= 1'b0;
        end else begin
            ir_sr_q  <= ir_sr_d;
            ir_q     <= ir_d;
            bypass_q <= bypass_d;
        end
    end

    // TDO source select; TDO holds outside shift states.
    always_comb begin
        tdo_d    = tdo_q;
        tdo_en_d = 1'b0;
        if (state == ST_SH_IR) begin
            tdo_d    = ir_sr_q[0];
            tdo_en_d = 1'b1;
        end else if (state == ST_SH_DR) begin
            tdo_d    = idr_select ? idr_tdo : bypass_q;
            tdo_en_d = 1'b1;
        end
    end

    // Falling-edge output flop for TDO and its enable.
    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_d;
            tdo_en_q <= tdo_en_d;
        end
    end

    assign TDO    = tdo_q;
    assign TDO_EN = tdo_en_q;

endmodule

// File: tb/tb_tap_ctrl.sv
// Directed bench for tap_ctrl with a 32-bit ID register model on idr_tdo.
module tb_tap_ctrl;
    import tap_pkg::*;

    logic       TCK, TRST, TMS, TDI;
    logic       TDO, TDO_EN, idr_tdo;
    logic       tlr_reset, dr_capture, dr_shift, dr_update;
    logic       idr_select, bypass_select;
    logic [3:0] ir_value, tap_state;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    logic [31:0] id_v = 32'h4BA0_0477;
    logic [31:0] idreg = '0;

    tap_ctrl #(
        .IR_WIDTH  (4),
        .IDCODE_OP (4'b0001),
        .BYPASS_OP (4'b1111)
    ) dut (
        .TCK           (TCK),
        .TRST          (TRST),
        .TMS           (TMS),
        .TDI           (TDI),
        .TDO           (TDO),
        .TDO_EN        (TDO_EN),
        .idr_tdo       (idr_tdo),
        .tlr_reset     (tlr_reset),
        .dr_capture    (dr_capture),
        .dr_shift      (dr_shift),
        .dr_update     (dr_update),
        .idr_select    (idr_select),
        .bypass_select (bypass_select),
        .ir_value      (ir_value),
        .tap_state     (tap_state)
    );

    initial TCK = 1'b0;
    always #5 TCK = ~TCK;

    // ID register model: captures on the edge leaving CAP_DR, shifts LSB first.
    always @(posedge TCK) begin
        if (dr_capture && idr_select)    idreg <= id_v;
        else if (dr_shift && idr_select) idreg <= {TDI, idreg[31:1]};
    end
    assign idr_tdo = idreg[0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clk(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        #1;
    endtask

    task automatic half();
        @(negedge TCK);
        #1;
    endtask

    // IR scan from RTI back to RTI; checks capture pattern and new decode.
    task automatic ir_scan(input logic [3:0] op, input logic [3:0] old_ir, input logic exp_idr);
        logic [3:0] cap;
        cap = 4'b0001;
        clk(1, 0); clk(1, 0); clk(0, 0);
        chk("cap_ir_state", tap_state, ST_CAP_IR);
        clk(0, 0);
        for (int i = 0; i < 4; i++) begin
            half();
            chk("ir_tdo", TDO, cap[i]);
            chk("ir_tdo_en", TDO_EN, 1);
            clk(i == 3, op[i]);
        end
        chk("ex1_ir_state", tap_state, ST_EX1_IR);
        clk(1, 0);
        chk("upd_ir_state", tap_state, ST_UPD_IR);
        chk("ir_before_upd", ir_value, old_ir);
        clk(0, 0);
        chk("ir_after_upd", ir_value, op);
        chk("idr_select", idr_select, exp_idr);
        chk("bypass_select", bypass_select, !exp_idr);
    endtask

    // IDCODE DR scan from RTI; optional 3-cycle PAUSE_DR after bit pause_at.
    task automatic dr_scan_id(input int pause_at);
        clk(1, 0); clk(0, 0);
        chk("cap_dr_state", tap_state, ST_CAP_DR);
        chk("dr_capture_hi", dr_capture, 1);
        clk(0, 0);
        chk("dr_capture_lo", dr_capture, 0);
        chk("dr_shift_hi", dr_shift, 1);
        for (int i = 0; i < 32; i++) begin
            half();
            chk("id_tdo", TDO, id_v[i]);
            chk("id_tdo_en", TDO_EN, 1);
            if (i == 31) begin
                clk(1, 0);
            end else if (i == pause_at) begin
                clk(1, 0);
                clk(0, 0);
                for (int p = 0; p < 3; p++) begin
                    chk("pause_state", tap_state, ST_PAUSE_DR);
                    chk("pause_shift", dr_shift, 0);
                    half();
                    chk("pause_tdo_en", TDO_EN, 0);
                    chk("pause_tdo_hold", TDO, id_v[i]);
                    clk(p == 2, 0);
                end
                chk("ex2_state", tap_state, ST_EX2_DR);
                clk(0, 0);
                chk("resume_state", tap_state, ST_SH_DR);
            end else begin
                clk(0, 1'(i));
            end
        end
        chk("ex1_dr_state", tap_state, ST_EX1_DR);
        clk(1, 0);
        chk("dr_update", dr_update, 1);
        clk(0, 0);
        chk("rti_state", tap_state, ST_RTI);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        logic [15:0] walk;
        logic [3:0]  exp_st [16];
        logic [3:0]  byp_in, byp_exp;
        walk   = 16'b1101_0011_1101_0010;
        exp_st = '{4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0, 4'h5,
                   4'h7, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};

        // Reset state
        TRST = 1'b1; TMS = 1'b1; TDI = 1'b0;
        #1 TRST = 1'b0;
        #1;
        chk("rst_state", tap_state, ST_TLR);
        chk("rst_ir", ir_value, 4'b0001);
        chk("rst_tlr", tlr_reset, 1);
        chk("rst_idr", idr_select, 1);
        chk("rst_byp", bypass_select, 0);
        chk("rst_strobes", {dr_capture, dr_shift, dr_update}, 0);
        chk("rst_tdo", TDO, 0);
        chk("rst_tdo_en", TDO_EN, 0);
        #5 TRST = 1'b1;
        clk(0, 0);
        chk("rti", tap_state, ST_RTI);
        chk("rti_tlr", tlr_reset, 0);

        // IDCODE scans, straight and with a pause
        dr_scan_id(-1);
        dr_scan_id(9);

        // Load BYPASS, then scan 1,0,1,1 through the bypass bit
        ir_scan(4'hF, 4'h1, 0);
        byp_in  = 4'b1101;
        byp_exp = 4'b1010;
        clk(1, 0); clk(0, 0);
        chk("byp_capture", dr_capture, 1);
        clk(0, 0);
        for (int i = 0; i < 4; i++) begin
            half();
            chk("byp_tdo", TDO, byp_exp[i]);
            clk(i == 3, byp_in[i]);
        end
        half();
        chk("byp_ex1_en", TDO_EN, 0);
        chk("byp_ex1_hold", TDO, 1);
        clk(1, 0); clk(0, 0);

        // Undecoded opcode
        ir_scan(4'b0110, 4'hF, 0);

        // TRST mid-SH_IR
        clk(1, 0); clk(1, 0); clk(0, 0); clk(0, 0);
        half();
        chk("midir_en", TDO_EN, 1);
        clk(0, 1); clk(0, 1);
        half();
        #2 TRST = 1'b0;
        #1;
        chk("trst_state", tap_state, ST_TLR);
        chk("trst_ir", ir_value, 4'b0001);
        chk("trst_tlr", tlr_reset, 1);
        chk("trst_tdo_en", TDO_EN, 0);
        chk("trst_idr", idr_select, 1);
        @(posedge TCK); #1;
        TRST = 1'b1;
        clk(0, 0);
        chk("trst_rti_ir", ir_value, 4'b0001);

        // Five TMS=1 edges reach TLR from every state
        for (int n = 0; n <= 16; n++) begin
            for (int k = 0; k < 5; k++) clk(1, 0);
            for (int j = 0; j < n; j++) clk(walk[j], 0);
            if (n > 0) chk("walk_state", tap_state, exp_st[n-1]);
            for (int k = 0; k < 5; k++) clk(1, 0);
            chk("walk_tlr", tap_state, ST_TLR);
            chk("walk_ir", ir_value, 4'b0001);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
